// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic master: accepts one read or write request
// at a time, runs one bus cycle, and returns the response with a timeout error flag.
module wb_master_bridge #(
  parameter int adr_width = 32,
  parameter int dat_width = 32,
  parameter int sel_width = dat_width / 8,
  parameter int timeout   = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bus_raddr_valid,
  output logic                 bus_raddr_ready,
  input  logic [adr_width-1:0] bus_raddr,
  output logic                 bus_rdata_valid,
  input  logic                 bus_rdata_ready,
  output logic [dat_width-1:0] bus_rdata,
  input  logic                 bus_waddr_valid,
  output logic                 bus_waddr_ready,
  input  logic [adr_width-1:0] bus_waddr,
  input  logic [dat_width-1:0] bus_wdata,
  input  logic [sel_width-1:0] bus_wstrb,
  output logic                 bus_wresp_valid,
  input  logic                 bus_wresp_ready,
  output logic                 bus_err,
  output logic [adr_width-1:0] wb_adr,
  output logic [dat_width-1:0] wb_datwr,
  input  logic [dat_width-1:0] wb_datrd,
  output logic                 wb_we,
  output logic                 wb_stb,
  input  logic                 wb_ack,
  output logic                 wb_cyc,
  output logic [sel_width-1:0] wb_sel
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid holds its payload until then, ready may depend on valid.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_CYC = 3'd1,
    RD_RSP = 3'd2,
    WR_CYC = 3'd3,
    WR_RSP = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(timeout);

  state_t     r_state;
  logic       r_prio_wr;
  logic [7:0] r_cnt;

  logic       w_idle;
  logic       w_rd_grant;
  logic       w_wr_grant;
  logic [7:0] w_cnt_inc;
  logic       w_tmo;

  // r_prio_wr set means the write side wins a tie in IDLE.
  assign w_idle     = (r_state == IDLE);
  assign w_rd_grant = w_idle && bus_raddr_valid && (!bus_waddr_valid || !r_prio_wr);
  assign w_wr_grant = w_idle && bus_waddr_valid && (!bus_raddr_valid || r_prio_wr);
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_tmo      = (w_cnt_inc == TMO_LIMIT);

  assign bus_raddr_ready = w_rd_grant;
  assign bus_waddr_ready = w_wr_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_prio_wr       <= 1'b0;
      r_cnt           <= 8'd0;
      wb_adr          <= '0;
      wb_datwr        <= '0;
      wb_sel          <= '0;
      wb_we           <= 1'b0;
      wb_cyc          <= 1'b0;
      wb_stb          <= 1'b0;
      bus_rdata       <= '0;
      bus_rdata_valid <= 1'b0;
      bus_wresp_valid <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_grant) begin
            wb_adr    <= bus_raddr;
            wb_we     <= 1'b0;
            wb_sel    <= '1;
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            r_cnt     <= 8'd0;
            r_prio_wr <= ~r_prio_wr;
            r_state   <= RD_CYC;
          end else if (w_wr_grant) begin
            wb_adr    <= bus_waddr;
            wb_datwr  <= bus_wdata;
            wb_sel    <= bus_wstrb;
            wb_we     <= 1'b1;
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            r_cnt     <= 8'd0;
            r_prio_wr <= ~r_prio_wr;
            r_state   <= WR_CYC;
          end
        end

        // An ack on the same edge as the timeout still counts as a good response.
        RD_CYC: begin
          if (wb_ack) begin
            bus_rdata       <= wb_datrd;
            bus_err         <= 1'b0;
            bus_rdata_valid <= 1'b1;
            wb_cyc          <= 1'b0;
            wb_stb          <= 1'b0;
            r_state         <= RD_RSP;
          end else if (w_tmo) begin
            r_cnt           <= w_cnt_inc;
            bus_rdata       <= '0;
            bus_err         <= 1'b1;
            bus_rdata_valid <= 1'b1;
            wb_cyc          <= 1'b0;
            wb_stb          <= 1'b0;
            r_state         <= RD_RSP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        RD_RSP: begin
          if (bus_rdata_ready) begin
            bus_rdata_valid <= 1'b0;
            r_state         <= IDLE;
          end
        end

        WR_CYC: begin
          if (wb_ack) begin
            bus_err         <= 1'b0;
            bus_wresp_valid <= 1'b1;
            wb_cyc          <= 1'b0;
            wb_stb          <= 1'b0;
            r_state         <= WR_RSP;
          end else if (w_tmo) begin
            r_cnt           <= w_cnt_inc;
            bus_err         <= 1'b1;
            bus_wresp_valid <= 1'b1;
            wb_cyc          <= 1'b0;
            wb_stb          <= 1'b0;
            r_state         <= WR_RSP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        WR_RSP: begin
          if (bus_wresp_ready) begin
            bus_wresp_valid <= 1'b0;
            r_state         <= IDLE;
          end
        end

        default: begin
          wb_cyc  <= 1'b0;
          wb_stb  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  a_cyc_eq_stb : assert property (@(posedge clock) disable iff (reset)
    wb_cyc == wb_stb);

  a_cycle_stable : assert property (@(posedge clock) disable iff (reset)
    (wb_cyc && $past(wb_cyc)) |-> ($stable(wb_adr) && $stable(wb_we) &&
                                   $stable(wb_sel) && $stable(wb_datwr)));

  a_one_response : assert property (@(posedge clock) disable iff (reset)
    !(bus_rdata_valid && bus_wresp_valid));

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomised bench for wb_master_bridge: a Wishbone slave model with programmable
// ack delay, a grant/response reference model, and directed corner cases.
module tb_wb_master_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 4;

  logic          clock;
  logic          reset;
  logic          bus_raddr_valid;
  logic          bus_raddr_ready;
  logic [AW-1:0] bus_raddr;
  logic          bus_rdata_valid;
  logic          bus_rdata_ready;
  logic [DW-1:0] bus_rdata;
  logic          bus_waddr_valid;
  logic          bus_waddr_ready;
  logic [AW-1:0] bus_waddr;
  logic [DW-1:0] bus_wdata;
  logic [SW-1:0] bus_wstrb;
  logic          bus_wresp_valid;
  logic          bus_wresp_ready;
  logic          bus_err;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_datwr;
  logic [DW-1:0] wb_datrd;
  logic          wb_we;
  logic          wb_stb;
  logic          wb_ack;
  logic          wb_cyc;
  logic [SW-1:0] wb_sel;

  int            n_checks;
  int            n_errors;
  bit            m_prio_wr;
  logic [33:0]   exp_q[$];

  int            slv_delay;
  int            slv_cnt;
  logic [31:0]   slv_data;
  bit            stray_en;

  wb_master_bridge #(
    .adr_width(AW), .dat_width(DW), .sel_width(SW), .timeout(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .bus_raddr_valid(bus_raddr_valid), .bus_raddr_ready(bus_raddr_ready),
    .bus_raddr(bus_raddr),
    .bus_rdata_valid(bus_rdata_valid), .bus_rdata_ready(bus_rdata_ready),
    .bus_rdata(bus_rdata),
    .bus_waddr_valid(bus_waddr_valid), .bus_waddr_ready(bus_waddr_ready),
    .bus_waddr(bus_waddr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_wresp_valid(bus_wresp_valid), .bus_wresp_ready(bus_wresp_ready),
    .bus_err(bus_err),
    .wb_adr(wb_adr), .wb_datwr(wb_datwr), .wb_datrd(wb_datrd), .wb_we(wb_we),
    .wb_stb(wb_stb), .wb_ack(wb_ack), .wb_cyc(wb_cyc), .wb_sel(wb_sel)
  );

  // clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Slave: acks on the (slv_delay+1)-th cycle of a bus cycle; optional stray acks outside.
  always @(negedge clock) begin
    if (reset || !wb_cyc) begin
      slv_cnt  = 0;
      wb_ack   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_datrd = $urandom;
    end else begin
      if (slv_cnt == slv_delay) begin
        wb_ack   = 1'b1;
        wb_datrd = slv_data;
      end else begin
        wb_ack   = 1'b0;
        wb_datrd = $urandom;
      end
      slv_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one transaction end to end; starts and ends just after a falling edge.
  task automatic run_txn(input bit rv, input bit wv, input logic [31:0] ra,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] rdat,
                         input int dly, input int bp, input bit keep);
    bit          g_wr;
    bit          tmo_hit;
    int          n;
    int          exp_n;
    logic [33:0] e;
    bus_raddr_valid = rv;
    bus_raddr       = ra;
    bus_waddr_valid = wv;
    bus_waddr       = wa;
    bus_wdata       = wd;
    bus_wstrb       = ws;
    slv_delay       = dly;
    slv_data        = rdat;
    g_wr    = wv && (!rv || m_prio_wr);
    tmo_hit = (dly >= TMO);
    #1;
    check("raddr_ready", 64'(bus_raddr_ready), 64'(rv && !g_wr));
    check("waddr_ready", 64'(bus_waddr_ready), 64'(g_wr));
    m_prio_wr = !m_prio_wr;
    exp_q.push_back({g_wr, tmo_hit, (g_wr || tmo_hit) ? 32'h0 : rdat});
    @(negedge clock);
    if (!keep) begin
      bus_raddr_valid = 1'b0;
      bus_waddr_valid = 1'b0;
    end
    n = 0;
    while (wb_cyc && n < 64) begin
      n++;
      check("wb_stb", 64'(wb_stb), 64'(1));
      check("wb_we", 64'(wb_we), 64'(g_wr));
      check("wb_adr", 64'(wb_adr), 64'(g_wr ? wa : ra));
      check("wb_sel", 64'(wb_sel), 64'(g_wr ? ws : 4'hF));
      if (g_wr) check("wb_datwr", 64'(wb_datwr), 64'(wd));
      check("busy_rready", 64'(bus_raddr_ready), 64'(0));
      check("busy_wready", 64'(bus_waddr_ready), 64'(0));
      check("busy_no_rsp", 64'({bus_rdata_valid, bus_wresp_valid}), 64'(0));
      @(negedge clock);
    end
    exp_n = tmo_hit ? TMO : dly + 1;
    check("cyc_len", 64'(n), 64'(exp_n));
    e = exp_q.pop_front();
    for (int i = 0; i <= bp; i++) begin
      check("rdata_valid", 64'(bus_rdata_valid), 64'(!e[33]));
      check("wresp_valid", 64'(bus_wresp_valid), 64'(e[33]));
      check("bus_err", 64'(bus_err), 64'(e[32]));
      if (!e[33]) check("bus_rdata", 64'(bus_rdata), 64'(e[31:0]));
      check("rsp_wb_cyc", 64'(wb_cyc), 64'(0));
      if (i == bp) begin
        if (e[33]) bus_wresp_ready = 1'b1;
        else bus_rdata_ready = 1'b1;
        #1;
      end
      check("rsp_rready", 64'(bus_raddr_ready), 64'(0));
      check("rsp_wready", 64'(bus_waddr_ready), 64'(0));
      @(negedge clock);
    end
    check("rsp_done", 64'({bus_rdata_valid, bus_wresp_valid}), 64'(0));
    check("done_cyc", 64'(wb_cyc), 64'(0));
    bus_rdata_ready = 1'b0;
    bus_wresp_ready = 1'b0;
  endtask

  task automatic reset_mid_write();
    bus_raddr_valid = 1'b0;
    bus_waddr_valid = 1'b1;
    bus_waddr       = 32'h300;
    bus_wdata       = 32'hA5A5_5A5A;
    bus_wstrb       = 4'hC;
    slv_delay       = 100;
    #1;
    check("rst_wready", 64'(bus_waddr_ready), 64'(1));
    @(negedge clock);
    check("rst_cyc_up", 64'(wb_cyc), 64'(1));
    bus_waddr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_cyc_async", 64'(wb_cyc), 64'(0));
    check("rst_stb_async", 64'(wb_stb), 64'(0));
    check("rst_we", 64'(wb_we), 64'(0));
    check("rst_adr", 64'(wb_adr), 64'(0));
    check("rst_sel", 64'(wb_sel), 64'(0));
    check("rst_wresp", 64'(bus_wresp_valid), 64'(0));
    m_prio_wr = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (TMO + 2) begin
      @(negedge clock);
      check("post_rst_wresp", 64'(bus_wresp_valid), 64'(0));
      check("post_rst_cyc", 64'(wb_cyc), 64'(0));
    end
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    m_prio_wr       = 1'b0;
    stray_en        = 1'b0;
    slv_delay       = 0;
    slv_data        = '0;
    reset           = 1'b1;
    bus_raddr_valid = 1'b0;
    bus_raddr       = '0;
    bus_rdata_ready = 1'b0;
    bus_waddr_valid = 1'b0;
    bus_waddr       = '0;
    bus_wdata       = '0;
    bus_wstrb       = '0;
    bus_wresp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_out_bus", 64'({bus_rdata_valid, bus_wresp_valid, bus_err,
                                bus_raddr_ready, bus_waddr_ready}), 64'(0));
    check("reset_out_wb", 64'({wb_cyc, wb_stb, wb_we, wb_sel}), 64'(0));
    check("reset_adr", 64'(wb_adr), 64'(0));
    check("reset_datwr", 64'(wb_datwr), 64'(0));
    check("reset_rdata", 64'(bus_rdata), 64'(0));
    reset = 1'b0;

    // directed: read with ack after 2 cycles, write, alternation, timeout, backpressure
    run_txn(1, 0, 32'h100, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, 0, 0);
    run_txn(0, 1, 32'h0, 32'h200, 32'h1234_5678, 4'h3, 32'h0, 1, 0, 0);
    for (int k = 0; k < 4; k++)
      run_txn(1, 1, 32'h400 + 32'(k), 32'h500 + 32'(k), $urandom, 4'(k + 1),
              $urandom, 0, 0, 1);
    bus_raddr_valid = 1'b0;
    bus_waddr_valid = 1'b0;
    run_txn(1, 0, 32'h600, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 10, 0, 0);
    run_txn(0, 1, 32'h0, 32'h640, 32'h0BAD_F00D, 4'hF, 32'h0, 10, 1, 0);
    run_txn(1, 0, 32'h680, 32'h0, 32'h0, 4'h0, 32'h1357_9BDF, TMO - 1, 0, 0);
    run_txn(1, 0, 32'h700, 32'h0, 32'h0, 4'h0, 32'h2468_ACE0, 0, 5, 1);
    bus_raddr_valid = 1'b0;

    reset_mid_write();
    run_txn(1, 1, 32'h800, 32'h900, 32'h1111_2222, 4'h5, 32'h7777_8888, 1, 0, 0);

    stray_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_txn(sel[0], sel[1], $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom, $urandom_range(0, 6), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end
    bus_raddr_valid = 1'b0;
    bus_waddr_valid = 1'b0;

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
